mon_prod_ws: RTL and testbench
==============================

# mon_prod_ws

Parametrised word-loaded Montgomery product engine, the next generation of `mon_prod`. It fetches operands from the shared dual-port BRAM as `WBITS`-wide limbs starting at runtime base addresses. It computes P = X·Y·2^-n mod M bit-serially over a runtime iteration count n, then fully reduces the result and optionally writes it back to BRAM. It sits between the modular-exponentiation sequencer (start/op_code/done handshake) and BRAM port 1.

## Interface
- `NBITS`, 1024: maximum operand/modulus width.
- `WBITS`, 512: BRAM data width; `NBITS` must be a multiple of `WBITS`.
- `ABITS`, 8: BRAM address width.
- `LIMBS`, `NBITS/WBITS` (localparam): limbs per operand.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request; sampled only in IDLE.
- `op_code`, in, 2: 0 = OPXX (X·X), 1 = OPXM (X·Y), 2 = OPX1 (X·1), 3 = reserved.
- `M`, in, `NBITS`: modulus; must be odd.
- `mp_count`, in, 11: iteration count n, valid range 1..`NBITS`.
- `x_addr`, in, `ABITS`: base address of the X limbs.
- `y_addr`, in, `ABITS`: base address of the Y limbs.
- `dst_addr`, in, `ABITS`: base address of the result limbs.
- `rd_addr`, out, `ABITS`: BRAM read address. BRAM read latency is 1 cycle.
- `rd_data`, in, `WBITS`: BRAM read data.
- `wr_addr`, out, `ABITS`: BRAM port-1 write address.
- `wr_data`, out, `WBITS`: BRAM port-1 write data.
- `wr_en`, out, 1: BRAM port-1 write enable.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: valid with `done`; request rejected.
- `P`, out, `NBITS`: result, always < M.

## Operation
- `start` sampled high in IDLE latches `op_code`, `M`, `mp_count` and all three base addresses. `start` is ignored at all other times.
- Validation happens at the accept edge. Reject the request if `op_code`==3, `mp_count`==0, `mp_count`>`NBITS`, or `M[0]`==0. On reject: go to DONE with `err`=1; `P` and BRAM are untouched.
- States and transitions:
  - IDLE → LOAD on an accepted, valid start.
  - LOAD issues nw sequential reads, low limb first. nw = 2·`LIMBS` for OPXM (X, then Y); nw = `LIMBS` otherwise. Y = X for OPXX; Y = 1 for OPX1. LOAD lasts nw+1 cycles to absorb the read latency.
  - MUL runs n cycles. Each cycle: P ← (P + x_i·Y + q·M) >> 1, where i = 0..n−1 and q = LSB of (P + x_i·Y). The accumulator is `NBITS`+2 bits wide.
  - SUB runs 1 cycle: if P ≥ M, P ← P − M.
  - STORE runs `LIMBS` cycles: limb k goes to `dst_addr`+k, low limb first.
  - DONE runs 1 cycle, then returns to IDLE.
- Address arithmetic wraps modulo 2^`ABITS`.
- `dst_addr` may equal `x_addr` for in-place squaring. All reads complete before any write.
- Operand bits above n are ignored (treated as zero).
- Reset values: state IDLE; `busy`, `done`, `err`, `wr_en` = 0; `P`, `rd_addr`, `wr_addr`, `wr_data` = 0.
- Reset asserted mid-operation aborts immediately. `wr_en` drops asynchronously, any partially written destination limbs are left as-is, and `done` is not pulsed.

## Timing
- `busy` is high from the edge after the accept edge through the last STORE cycle.
- `busy` is low in DONE, so a new `start` can be accepted in the cycle after DONE.
- The valid-path `done` pulse rises (nw+1) + n + 1 + `LIMBS` clocks after the accept edge. Example: OPXM, `LIMBS`=2, n=10 gives 18 clocks.
- The reject-path `done` pulse rises 1 clock after the accept edge, with `busy` never asserted.
- `P` is updated at the end of SUB and holds until the next accepted valid start.
- `wr_en` is high for exactly `LIMBS` consecutive cycles per valid operation.

## Configuration
- `MON_PROD_WRITEBACK_EN` defined: the STORE state is present and the result is written to BRAM as above.
- `MON_PROD_WRITEBACK_EN` undefined:
  - STORE is skipped; SUB goes straight to DONE.
  - `wr_en`, `wr_addr` and `wr_data` are tied to 0.
  - The valid-path latency drops by `LIMBS` clocks.
  - The result is available only on `P`.

## Test plan
All scenarios use `LIMBS`=2, M=589 and n=10, with writeback enabled unless stated.
1. OPXM: X=435 at addresses 0/1, Y=535 at 2/3, `dst_addr`=4 → `P`=535; BRAM[4]=535, BRAM[5]=0; `done` rises 18 clocks after accept.
2. OPXX in place: X=435, `x_addr`=`dst_addr`=0 → `P`=435; BRAM[0]=435; `done` after 16 clocks.
3. OPX1: X=435 → `P`=1 (leaves the Montgomery domain).
4. Rejects: `mp_count`=0, then M=588, then `op_code`=3 → each gives `done`=`err`=1 one clock after accept; no `wr_en` activity; `P` unchanged.
5. `rst_n` pulsed low during MUL of scenario 1 → all outputs 0 immediately; a restart then yields `P`=535.
6. `start` held high throughout scenario 1, and a build without `MON_PROD_WRITEBACK_EN` → second operation begins the cycle after DONE; in the no-writeback build `wr_en` stays 0 and `done` comes after 16 clocks.

Source files
------------

// File: rtl/mon_prod_ws.sv
// mon_prod_ws: word-loaded bit-serial Montgomery product P = X*Y*2^-n mod M.
// `MON_PROD_WRITEBACK_EN adds the STORE pass that writes P back to BRAM.
module mon_prod_ws #(
  parameter int NBITS = 1024,
  parameter int WBITS = 512,
  parameter int ABITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_code,
  input  logic [NBITS-1:0] M,
  input  logic [10:0]      mp_count,
  input  logic [ABITS-1:0] x_addr,
  input  logic [ABITS-1:0] y_addr,
  input  logic [ABITS-1:0] dst_addr,
  output logic [ABITS-1:0] rd_addr,
  input  logic [WBITS-1:0] rd_data,
  output logic [ABITS-1:0] wr_addr,
  output logic [WBITS-1:0] wr_data,
  output logic             wr_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NBITS-1:0] P
);
  localparam int LIMBS = NBITS / WBITS;
  localparam int AW = NBITS + 2;
  localparam logic [1:0] OPXX = 2'd0;
  localparam logic [1:0] OPXM = 2'd1;
  localparam logic [1:0] OPX1 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_REJ, S_LOAD, S_MUL,
    S_SUB, S_STORE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [NBITS-1:0] m_q;
  logic [10:0]      n_q;
  logic [10:0]      cnt_q;
  logic [ABITS-1:0] xa_q, ya_q;
  logic [NBITS-1:0] x_q, y_q;
  logic [AW-1:0]    acc_q, acc_d;
  logic [NBITS-1:0] p_q;
  logic             err_q;
  logic             bad;
  int               nw;
  logic [NBITS-1:0] y_m;
  logic [AW:0]      sum0;
  logic             ge;
  logic [NBITS-1:0] dif;

`ifdef MON_PROD_WRITEBACK_EN
  logic [ABITS-1:0] da_q;
`else
  logic unused_dst;
  assign unused_dst = ^dst_addr;
`endif

  assign P = p_q;

  // request validation and load word count
  always_comb begin
    bad = (op_code == 2'd3) || (mp_count == 11'd0) ||
          (int'(mp_count) > NBITS) || !M[0];
    nw = (op_q == OPXM) ? 2 * LIMBS : LIMBS;
  end

  // one Montgomery step plus the final conditional subtract
  always_comb begin
    y_m = y_q & ~({NBITS{1'b1}} << n_q);
    sum0 = {1'b0, acc_q} + (x_q[0] ? {3'b000, y_m} : '0);
    acc_d = AW'((sum0 + (sum0[0] ? {3'b000, m_q} : '0)) >> 1);
    ge = acc_q >= {2'b00, m_q};
    dif = acc_q[NBITS-1:0] - m_q;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = bad ? S_REJ : S_LOAD;
      S_REJ:   state_d = S_DONE;
      S_LOAD:  if (int'(cnt_q) == nw) state_d = S_MUL;
      S_MUL:   if (cnt_q == n_q - 11'd1) state_d = S_SUB;
`ifdef MON_PROD_WRITEBACK_EN
      S_SUB:   state_d = S_STORE;
      S_STORE: if (int'(cnt_q) == LIMBS - 1) state_d = S_DONE;
`else
      S_SUB:   state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    err = 1'b0;
    rd_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state_q)
      S_LOAD: begin
        busy = 1'b1;
        if (int'(cnt_q) < LIMBS)
          rd_addr = xa_q + ABITS'(cnt_q);
        else if (int'(cnt_q) < nw)
          rd_addr = ya_q + ABITS'(cnt_q - 11'(LIMBS));
      end
      S_MUL, S_SUB: busy = 1'b1;
      S_STORE: begin
        busy = 1'b1;
`ifdef MON_PROD_WRITEBACK_EN
        wr_en = 1'b1;
        wr_addr = da_q + ABITS'(cnt_q);
        for (int k = 0; k < LIMBS; k++)
          if (int'(cnt_q) == k)
            wr_data = p_q[k*WBITS +: WBITS];
`endif
      end
      S_DONE: begin
        done = 1'b1;
        err = err_q;
      end
      default: ;
    endcase
  end

  // operand capture, multiply loop and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      m_q <= '0;
      n_q <= '0;
      cnt_q <= '0;
      xa_q <= '0;
      ya_q <= '0;
      x_q <= '0;
      y_q <= '0;
      acc_q <= '0;
      p_q <= '0;
      err_q <= 1'b0;
`ifdef MON_PROD_WRITEBACK_EN
      da_q <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          op_q <= op_code;
          m_q <= M;
          n_q <= mp_count;
          xa_q <= x_addr;
          ya_q <= y_addr;
`ifdef MON_PROD_WRITEBACK_EN
          da_q <= dst_addr;
`endif
          err_q <= bad;
          cnt_q <= '0;
          acc_q <= '0;
          if (op_code == OPX1) y_q <= NBITS'(1);
        end
        S_LOAD: begin
          for (int k = 0; k < LIMBS; k++) begin
            if (int'(cnt_q) == k + 1) begin
              x_q[k*WBITS +: WBITS] <= rd_data;
              if (op_q == OPXX)
                y_q[k*WBITS +: WBITS] <= rd_data;
            end
            if (op_q == OPXM && int'(cnt_q) == LIMBS + k + 1)
              y_q[k*WBITS +: WBITS] <= rd_data;
          end
          cnt_q <= (int'(cnt_q) == nw) ? '0 : cnt_q + 11'd1;
        end
        S_MUL: begin
          x_q <= x_q >> 1;
          acc_q <= acc_d;
          cnt_q <= (cnt_q == n_q - 11'd1) ? '0 : cnt_q + 11'd1;
        end
        S_SUB: p_q <= ge ? dif : acc_q[NBITS-1:0];
        S_STORE: cnt_q <= cnt_q + 11'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mon_prod_ws.sv
// tb_mon_prod_ws: directed and random checks of mon_prod_ws against an
// arithmetic Montgomery reference and a behavioural BRAM.
module tb_mon_prod_ws;
  localparam int NB = 16;
  localparam int WD = 8;
  localparam int AB = 8;
  localparam int LIMBS = NB / WD;
`ifdef MON_PROD_WRITEBACK_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op_code = '0;
  logic [NB-1:0] M = '0;
  logic [10:0]   mp_count = '0;
  logic [AB-1:0] x_addr = '0, y_addr = '0, dst_addr = '0;
  logic [AB-1:0] rd_addr, wr_addr;
  logic [WD-1:0] rd_data, wr_data;
  logic          wr_en, busy, done, err;
  logic [NB-1:0] P;

  logic          tb_we = 1'b0;
  logic [7:0]    tb_wa = '0, tb_wd = '0;
  logic [7:0]    mem [256];
  int            wr_cnt = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [15:0]   p_last = '0;

  always #5 clk = ~clk;

  mon_prod_ws #(.NBITS(NB), .WBITS(WD), .ABITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code),
    .M(M), .mp_count(mp_count), .x_addr(x_addr), .y_addr(y_addr),
    .dst_addr(dst_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done), .err(err), .P(P)
  );

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (tb_we) mem[tb_wa] <= tb_wd;
    rd_data <= mem[rd_addr];
    if (wr_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mont_ref(input longint x,
      input longint y, input longint m, input int n);
    longint p, h;
    p = (x * y) % m;
    h = (m + 1) / 2;
    for (int i = 0; i < n; i++) p = (p * h) % m;
    return 16'(p);
  endfunction

  task automatic preload(input logic [7:0] a, input logic [15:0] v);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = v[7:0];
    @(posedge clk); #1;
    tb_wa = a + 8'd1;
    tb_wd = v[15:8];
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
      input logic [15:0] m, input logic [10:0] n,
      input logic [7:0] xa, input logic [7:0] ya, input logic [7:0] da,
      input logic [15:0] xv, input logic [15:0] yv, input bit bad);
    logic [15:0] pexp, ye;
    logic [7:0]  da1;
    int lat, w0, lexp;
    bit sb;
    if (!bad) begin
      preload(xa, xv);
      if (op == 2'd1) preload(ya, yv);
    end
    ye = (op == 2'd0) ? xv : (op == 2'd2) ? 16'd1 : yv;
    pexp = bad ? p_last : mont_ref(longint'(xv), longint'(ye),
                                   longint'(m), int'(n));
    lexp = bad ? 1 : ((op == 2'd1) ? 2 * LIMBS : LIMBS) + 1 +
           int'(n) + 1 + WB * LIMBS;
    da1 = da + 8'd1;
    w0 = wr_cnt;
    sb = 1'b0;
    start = 1'b1;
    op_code = op;
    M = m;
    mp_count = n;
    x_addr = xa;
    y_addr = ya;
    dst_addr = da;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    if (busy) sb = 1'b1;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (busy) sb = 1'b1;
    end
    chk({tag, "_lat"}, lat, lexp);
    chk({tag, "_err"}, err, bad);
    chk({tag, "_busy"}, sb, !bad);
    chk({tag, "_p"}, P, pexp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_wr"}, wr_cnt - w0, bad ? 0 : WB * LIMBS);
`ifdef MON_PROD_WRITEBACK_EN
    if (!bad) chk({tag, "_mem"}, {mem[da1], mem[da]}, pexp);
`endif
    if (!bad) p_last = pexp;
  endtask

  initial begin
    int lat, g, w0, lim, n;
    logic [15:0] m, xv, yv;
    logic [7:0]  xa, ya, da;
    logic [1:0]  op;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", {done, err, wr_en}, 0);
    chk("rst_p", P, 0);
    chk("rst_addr", {rd_addr, wr_addr, wr_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("s1_opxm", 2'd1, 16'd589, 11'd10, 8'd0, 8'd2, 8'd4,
           16'd435, 16'd535, 1'b0);
    chk("s1_const", P, 535);
    run_op("s2_opxx", 2'd0, 16'd589, 11'd10, 8'd0, 8'd0, 8'd0,
           16'd435, 16'd0, 1'b0);
    chk("s2_const", P, 435);
    run_op("s3_opx1", 2'd2, 16'd589, 11'd10, 8'd0, 8'd0, 8'd6,
           16'd435, 16'd0, 1'b0);
    chk("s3_const", P, 1);

    run_op("r_n0", 2'd1, 16'd589, 11'd0, 8'd0, 8'd2, 8'd4,
           16'd0, 16'd0, 1'b1);
    run_op("r_meven", 2'd1, 16'd588, 11'd10, 8'd0, 8'd2, 8'd4,
           16'd0, 16'd0, 1'b1);
    run_op("r_op3", 2'd3, 16'd589, 11'd10, 8'd0, 8'd2, 8'd4,
           16'd0, 16'd0, 1'b1);
    run_op("r_nbig", 2'd1, 16'd589, 11'd17, 8'd0, 8'd2, 8'd4,
           16'd0, 16'd0, 1'b1);

    preload(8'd0, 16'd435);
    preload(8'd2, 16'd535);
    start = 1'b1;
    op_code = 2'd1;
    M = 16'd589;
    mp_count = 11'd10;
    x_addr = 8'd0;
    y_addr = 8'd2;
    dst_addr = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_p", P, 0);
    chk("mid_rst_rd", rd_addr, 0);
    chk("mid_rst_out", {done, err, wr_en, wr_addr, wr_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    p_last = '0;
    @(posedge clk); #1;
    run_op("s5_restart", 2'd1, 16'd589, 11'd10, 8'd0, 8'd2, 8'd4,
           16'd435, 16'd535, 1'b0);

    w0 = wr_cnt;
    start = 1'b1;
    op_code = 2'd1;
    M = 16'd589;
    mp_count = 11'd10;
    x_addr = 8'd0;
    y_addr = 8'd2;
    dst_addr = 8'd4;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat1", lat, 4 + 1 + 10 + 1 + WB * LIMBS);
    g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (!done && g < 400);
    start = 1'b0;
    chk("hold_gap", g, 4 + 1 + 10 + 1 + WB * LIMBS + 2);
    chk("hold_p", P, 535);
    @(posedge clk); #1;
    chk("hold_wr", wr_cnt - w0, 2 * WB * LIMBS);
    chk("hold_idle", {busy, done}, 0);

    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(1, 16);
      m = 16'($urandom_range(1, 65535)) | 16'd1;
      lim = (int'(m) < (1 << n)) ? int'(m) : (1 << n);
      xv = 16'($urandom_range(0, lim - 1));
      yv = 16'($urandom_range(0, lim - 1));
      op = 2'($urandom_range(0, 2));
      xa = 8'($urandom_range(0, 255));
      ya = xa + 8'd2 + 8'($urandom_range(0, 200));
      da = 8'($urandom_range(0, 255));
      run_op($sformatf("rnd%0d", i), op, m, 11'(n), xa, ya, da,
             xv, yv, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
